// File: rtl/ft245_pkg.sv
// Shared types for the FT245 transmit framer.
// FSM state encoding plus the default frame sync marker.
package ft245_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    GAP
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bytes on the wire for one FIFO entry.
  function automatic int frame_bytes(
    input int width,
    input int header_en
  );
    return (width / 8) + ((header_en != 0) ? 2 : 0);
  endfunction

endpackage

// File: rtl/ft245_tx_framer_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-around pointers.
// A write becomes visible to the reader one cycle after the push.
module sync_fifo
  import ft245_pkg::*;
#(
  parameter int DW    = 34,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0] wp_q;
  logic [AW:0] wp_d;
  logic [AW:0] rp_q;
  logic [AW:0] rp_d;
  logic [AW:0] vis_q;
  logic [AW:0] vis_d;

  logic push_ok;
  logic pop_ok;

  assign full = (wp_q[AW] != rp_q[AW]) &&
                (wp_q[AW-1:0] == rp_q[AW-1:0]);

  // Reader compares against the delayed write pointer.
  assign empty = (vis_q == rp_q);

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign dout = mem_q[rp_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    vis_d = wp_q;
    if (push_ok) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop_ok) begin
      rp_d = rp_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      vis_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      vis_q <= vis_d;
    end
  end

  // Storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ft245_tx_framer.sv
// FT245 transmit framer: buffers channel-tagged pulse heights
// and writes them out as framed bytes with timed WR strobes.
module ft245_tx_framer
  import ft245_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 16,
  parameter int          CH_BITS   = 2,
  parameter int          HEADER_EN = 1,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int          WR_SETUP  = 1,
  parameter int          WR_PULSE  = 1,
  parameter int          OVF_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [CH_BITS-1:0]  in_channel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                txe,
  output logic                wr,
  output logic                rd,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic                busy,
  output logic [OVF_BITS-1:0] overflow_cnt
);

  localparam int NB = frame_bytes(WIDTH, HEADER_EN);
  localparam int FW = NB * 8;
  localparam int EW = WIDTH + CH_BITS;
  localparam int CW = 16;

  localparam logic [CW-1:0] SETUP_LAST = CW'(WR_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(WR_PULSE - 1);
  localparam logic [3:0]    LAST_IDX   = 4'(NB - 1);

  logic          f_push;
  logic          f_pop;
  logic [EW-1:0] f_din;
  logic [EW-1:0] f_dout;
  logic          f_full;
  logic          f_empty;

  logic [7:0]    ch8;
  logic [FW-1:0] frame;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    idx_q;
  logic [3:0]    idx_d;
  logic [FW-1:0] shift_q;
  logic [FW-1:0] shift_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          wr_q;
  logic          wr_d;
  logic          oe_q;
  logic          oe_d;

  logic [OVF_BITS-1:0] ovf_q;
  logic [OVF_BITS-1:0] ovf_d;

  assign f_push = in_valid && !f_full;
  assign f_din  = {in_channel, in_data};

  sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .din   (f_din),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  // Zero-extend the channel ID of the head entry to a byte.
  always_comb begin
    ch8 = '0;
    ch8[CH_BITS-1:0] = f_dout[EW-1:WIDTH];
  end

  // Frame image of the head entry, byte 0 in the low bits.
  if (HEADER_EN != 0) begin : g_hdr
    assign frame = {f_dout[WIDTH-1:0], ch8, SYNC_BYTE};
  end else begin : g_nohdr
    assign frame = f_dout[WIDTH-1:0];
  end

  // Framer next-state: byte load, setup, strobe, wait, gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = wr_q;
    oe_d    = oe_q;
    f_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!f_empty && !txe) begin
          f_pop   = 1'b1;
          data_d  = frame[7:0];
          shift_d = frame >> 8;
          oe_d    = 1'b1;
          wr_d    = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          wr_d    = 1'b0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          wr_d  = 1'b1;
          if (idx_q == LAST_IDX) begin
            oe_d    = 1'b0;
            state_d = GAP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // Device space is only checked between bytes.
        if (!txe) begin
          data_d  = shift_q[7:0];
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 1'b1;
          state_d = SETUP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating count of pushes dropped on a full FIFO.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && f_full && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  // Framer state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = !f_full;
  assign wr           = wr_q;
  assign rd           = 1'b1;
  assign data_out     = data_q;
  assign data_oe      = oe_q;
  assign busy         = (state_q != IDLE) || !f_empty;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ft245_tx_framer.sv
// Scoreboard bench for ft245_tx_framer: default build plus a
// 16-bit headerless build with WR_SETUP=3, WR_PULSE=2.
module tb_ft245_tx_framer;

  logic clk;
  logic reset;

  logic [31:0] in_data1;
  logic [1:0]  in_ch1;
  logic        in_valid1;
  logic        in_ready1;
  logic        txe1;
  logic        wr1;
  logic        rd1;
  logic [7:0]  dout1;
  logic        oe1;
  logic        busy1;
  logic [15:0] ovf1;

  logic [15:0] in_data2;
  logic [1:0]  in_ch2;
  logic        in_valid2;
  logic        in_ready2;
  logic        txe2;
  logic        wr2;
  logic        rd2;
  logic [7:0]  dout2;
  logic        oe2;
  logic        busy2;
  logic [15:0] ovf2;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  int         stab[2];
  int         lowc[2];
  int         nby[2];
  int         lastfall[2];
  logic       pwr[2];
  logic       lowok[2];
  logic [7:0] pdat[2];

  ft245_tx_framer u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data1),
    .in_channel   (in_ch1),
    .in_valid     (in_valid1),
    .in_ready     (in_ready1),
    .txe          (txe1),
    .wr           (wr1),
    .rd           (rd1),
    .data_out     (dout1),
    .data_oe      (oe1),
    .busy         (busy1),
    .overflow_cnt (ovf1)
  );

  ft245_tx_framer #(
    .WIDTH     (16),
    .HEADER_EN (0),
    .WR_SETUP  (3),
    .WR_PULSE  (2)
  ) u_dut2 (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data2),
    .in_channel   (in_ch2),
    .in_valid     (in_valid2),
    .in_ready     (in_ready2),
    .txe          (txe2),
    .wr           (wr2),
    .rd           (rd2),
    .data_out     (dout2),
    .data_oe      (oe2),
    .busy         (busy2),
    .overflow_cnt (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  // Monitor: on each WR fall pop the scoreboard and check timing.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       w;
      logic       oe;
      logic [7:0] d;
      int         su;
      int         pu;
      w  = (k == 0) ? wr1 : wr2;
      oe = (k == 0) ? oe1 : oe2;
      d  = (k == 0) ? dout1 : dout2;
      su = (k == 0) ? 1 : 3;
      pu = (k == 0) ? 1 : 2;
      if (reset) begin
        pwr[k]  = w;
        pdat[k] = d;
        stab[k] = 0;
        lowc[k] = 0;
      end else begin
        if (!w && pwr[k]) begin
          nby[k]++;
          lastfall[k] = cyc;
          chk("setup_cycles", stab[k], su);
          chk("oe_at_strobe", oe, 1);
          if (k == 0) begin
            chk("byte_expected0", exp0.size() != 0, 1);
            if (exp0.size() != 0) chk("byte0", d, exp0.pop_front());
          end else begin
            chk("byte_expected1", exp1.size() != 0, 1);
            if (exp1.size() != 0) chk("byte1", d, exp1.pop_front());
          end
          lowc[k]  = 1;
          lowok[k] = 1'b1;
        end else if (!w) begin
          lowc[k]++;
          if (d !== pdat[k]) lowok[k] = 1'b0;
        end else if (!pwr[k]) begin
          chk("pulse_cycles", lowc[k], pu);
          chk("hold_while_low", lowok[k], 1);
          stab[k] = 1;
        end else begin
          stab[k] = (d === pdat[k]) ? stab[k] + 1 : 1;
        end
        pwr[k]  = w;
        pdat[k] = d;
      end
    end
  end

  task automatic frame1(input logic [1:0] ch, input logic [31:0] d);
    exp0.push_back(8'hA5);
    exp0.push_back({6'b0, ch});
    for (int b = 0; b < 4; b++) exp0.push_back(d[b*8 +: 8]);
  endtask

  task automatic push1(input logic [1:0] ch, input logic [31:0] d,
                       output int pc);
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    in_ch1    = ch;
    in_data1  = d;
    @(posedge clk); #1;
    pc = cyc;
    in_valid1 = 1'b0;
  endtask

  task automatic push2(input logic [15:0] d, output int pc);
    @(posedge clk); #1;
    in_valid2 = 1'b1;
    in_ch2    = 2'd1;
    in_data2  = d;
    @(posedge clk); #1;
    pc = cyc;
    in_valid2 = 1'b0;
  endtask

  task automatic drain(input int k, input int budget);
    int n = 0;
    while (n < budget &&
           ((k == 0) ? (exp0.size() != 0 || busy1)
                     : (exp1.size() != 0 || busy2))) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic wait_bytes(input int k, input int target);
    int n = 0;
    while (nby[k] < target && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("byte_wait_in_budget", n < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int p;
    int base;
    int ok;
    for (int k = 0; k < 2; k++) begin
      nby[k] = 0; stab[k] = 0; lowc[k] = 0;
      pwr[k] = 1'b1; lowok[k] = 1'b1; pdat[k] = 8'h00;
      lastfall[k] = 0;
    end
    reset     = 1'b1;
    in_valid1 = 1'b0; in_ch1 = '0; in_data1 = '0; txe1 = 1'b0;
    in_valid2 = 1'b0; in_ch2 = '0; in_data2 = '0; txe2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", wr1, 1);
    chk("rst_rd", rd1, 1);
    chk("rst_data", dout1, 0);
    chk("rst_oe", oe1, 0);
    chk("rst_ready", in_ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_rd2", rd2, 1);
    chk("rst_ready2", in_ready2, 1);
    chk("rst_ovf2", ovf2, 0);
    reset = 1'b0;

    // Default frame, header on.
    base = nby[0];
    frame1(2'd2, 32'h11223344);
    push1(2'd2, 32'h11223344, p);
    wait_bytes(0, base + 1);
    chk("first_strobe_latency", lastfall[0] - p, 3);
    chk("busy_in_frame", busy1, 1);
    drain(0, 200);
    chk("frame_bytes", nby[0] - base, 6);

    // Headerless 16-bit build with long setup and pulse.
    base = nby[1];
    exp1.push_back(8'hEF);
    exp1.push_back(8'hBE);
    push2(16'hBEEF, p);
    wait_bytes(1, base + 1);
    chk("first_strobe_latency2", lastfall[1] - p, 5);
    drain(1, 200);
    chk("frame_bytes2", nby[1] - base, 2);

    // TXE high between bytes stalls the frame.
    base = nby[0];
    frame1(2'd1, 32'h0D0C0B0A);
    push1(2'd1, 32'h0D0C0B0A, p);
    wait_bytes(0, base + 3);
    txe1 = 1'b1;
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (wr1 !== 1'b1 || dout1 !== 8'h0A) ok = 0;
    end
    chk("txe_stall_hold", ok, 1);
    chk("txe_stall_bytes", nby[0] - base, 3);
    @(posedge clk); #1;
    txe1 = 1'b0;
    p = cyc;
    wait_bytes(0, base + 4);
    chk("resume_latency", lastfall[0] - p, 2);
    drain(0, 200);

    // Overflow: 18 pushes into 16 entries with TXE high.
    txe1 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      logic [31:0] d;
      @(posedge clk); #1;
      chk("in_ready_fill", in_ready1, (i < 16) ? 1 : 0);
      d = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
      if (i < 16) frame1(2'(i), d);
      in_valid1 = 1'b1;
      in_ch1    = 2'(i);
      in_data1  = d;
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("overflow_cnt", ovf1, 2);
    chk("in_ready_full", in_ready1, 0);
    base = nby[0];
    txe1 = 1'b0;
    drain(0, 3000);
    chk("overflow_frames_bytes", nby[0] - base, 96);

    // Reset while WR is low aborts the frame and empties the FIFO.
    push1(2'd3, 32'h55667788, p);
    push1(2'd0, 32'h99AABBCC, p);
    ok = 0;
    for (int n = 0; n < 50 && ok == 0; n++) begin
      @(posedge clk); #1;
      if (wr1 === 1'b0) ok = 1;
    end
    chk("strobe_before_reset", ok, 1);
    reset = 1'b1;
    exp0.delete();
    @(posedge clk); #1;
    chk("abort_wr", wr1, 1);
    chk("abort_oe", oe1, 0);
    chk("abort_empty_busy", busy1, 0);
    chk("abort_ready", in_ready1, 1);
    chk("abort_ovf", ovf1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    base = nby[0];
    repeat (40) @(posedge clk);
    #1;
    chk("no_leftover_bytes", nby[0] - base, 0);
    chk("idle_after_abort", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
